// File: rtl/frame_tick_gen.sv
// frame_tick_gen
//
// Divides the system clock into fixed frame periods and emits a one-cycle
// frame_tick at each frame boundary for the frame counter and the box
// animation FSMs. If the downstream draw logic is busy at a boundary, the
// tick is deferred until it is ready. Boundaries that pass while a tick is
// already owed are merged into that single owed tick.
//
// Parameters
//   CLKS_PER_FRAME  clocks per frame period (>= 2)
//   CW              period counter width, 2**CW >= CLKS_PER_FRAME
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   enable         run control; low pauses the generator
//   draw_busy      downstream draw logic busy; no tick while high
//   clear_overrun  one-cycle pulse clearing overrun
//   frame_tick     registered one-cycle frame boundary pulse
//   frame_num      issued tick count, mod 256
//   pending        a tick is owed but deferred
//   overrun        sticky: a boundary was reached with a tick already owed
//
// Build option
//   FRAME_TICK_OVERRUN_EN  when defined, implements the sticky overrun flag
//                          and clear_overrun; otherwise overrun is tied low
//                          and clear_overrun is ignored.

module frame_tick_gen #(
  parameter int unsigned CLKS_PER_FRAME = 833333,
  parameter int unsigned CW             = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       draw_busy,
  input  logic       clear_overrun,
  output logic       frame_tick,
  output logic [7:0] frame_num,
  output logic       pending,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam logic [CW-1:0] TC_VAL = CW'(CLKS_PER_FRAME - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          started;
  logic          tc;
  logic          cnt_run;
  logic          issue;
  logic          ovr_evt;

  assign tc      = (cnt == TC_VAL);
  assign pending = (state == PEND);

  // started records that the one-edge startup latency has been paid since
  // reset. Re-entering IDLE through a pause must not cost an extra edge, so
  // an enabled IDLE cycle after startup behaves exactly like a RUN cycle
  // (it counts and evaluates TC); only the first enabled edge after reset
  // leaves cnt untouched.
  always_comb begin
    state_next = state;
    cnt_run    = 1'b0;
    issue      = 1'b0;
    ovr_evt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          if (!started) begin
            state_next = RUN;
          end else begin
            cnt_run = 1'b1;
            if (tc && draw_busy) begin
              state_next = PEND;
            end else begin
              state_next = RUN;
              issue      = tc;
            end
          end
        end
      end
      RUN: begin
        if (!enable) begin
          state_next = IDLE;
        end else begin
          cnt_run = 1'b1;
          if (tc && draw_busy) begin
            state_next = PEND;
          end else begin
            issue = tc;
          end
        end
      end
      PEND: begin
        // The counter keeps running through the new frame so the period
        // grid is not stretched by the deferral. A boundary here is merged
        // into the tick already owed.
        if (enable) begin
          cnt_run = 1'b1;
          ovr_evt = tc;
          if (!draw_busy) begin
            issue      = 1'b1;
            state_next = RUN;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    cnt_next = cnt;
    if (cnt_run) begin
      if (tc) begin
        cnt_next = '0;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      started    <= 1'b0;
      frame_tick <= 1'b0;
      frame_num  <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      started    <= started | enable;
      frame_tick <= issue;
      if (issue) begin
        frame_num <= frame_num + 8'd1;
      end
    end
  end

`ifdef FRAME_TICK_OVERRUN_EN
  // A new overrun event takes priority over a coincident clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (ovr_evt) begin
      overrun <= 1'b1;
    end else if (clear_overrun) begin
      overrun <= 1'b0;
    end
  end
`else
  assign overrun = 1'b0;

  logic unused_ovr;
  assign unused_ovr = clear_overrun ^ ovr_evt;
`endif

endmodule

// File: tb/tb_frame_tick_gen.sv
// Testbench for frame_tick_gen with a short frame period (4 clocks).
// Directed vector table, hand-written overrun and wrap sequences, and a
// randomized run compared against a behavioural model.

module tb_frame_tick_gen;

  localparam int unsigned N = 4;

`ifdef FRAME_TICK_OVERRUN_EN
  localparam int OVR_ON = 1;
`else
  localparam int OVR_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       draw_busy;
  logic       clear_overrun;
  logic       frame_tick;
  logic [7:0] frame_num;
  logic       pending;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  frame_tick_gen #(
    .CLKS_PER_FRAME(N),
    .CW            (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .draw_busy    (draw_busy),
    .clear_overrun(clear_overrun),
    .frame_tick   (frame_tick),
    .frame_num    (frame_num),
    .pending      (pending),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Behavioural model: a frame phase that advances on every enabled cycle
  // once started, and a single "owed tick" flag.
  bit m_started;
  int m_phase;
  bit m_owed;
  bit m_tick;
  int m_num;
  bit m_ovr;

  task automatic model_step(input bit r, input bit e, input bit b, input bit c);
    bit boundary;
    bit evt;
    evt = 1'b0;
    if (r) begin
      m_started = 1'b0;
      m_phase   = 0;
      m_owed    = 1'b0;
      m_tick    = 1'b0;
      m_num     = 0;
      m_ovr     = 1'b0;
    end else begin
      m_tick = 1'b0;
      if (e) begin
        if (!m_started) begin
          m_started = 1'b1;
        end else begin
          boundary = (m_phase == int'(N) - 1);
          m_phase  = (m_phase + 1) % int'(N);
          if (boundary) begin
            evt    = m_owed;
            m_owed = 1'b1;
          end
          if (m_owed && !b) begin
            m_tick = 1'b1;
            m_owed = 1'b0;
            m_num  = (m_num + 1) % 256;
          end
        end
      end
      if (OVR_ON != 0) begin
        if (evt) m_ovr = 1'b1;
        else if (c) m_ovr = 1'b0;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit e, input bit b, input bit c);
    reset         = r;
    enable        = e;
    draw_busy     = b;
    clear_overrun = c;
    @(posedge clk);
    model_step(r, e, b, c);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_tick"}, int'(frame_tick), int'(m_tick));
    chk({tag, "_num"},  int'(frame_num),  m_num);
    chk({tag, "_pend"}, int'(pending),    int'(m_owed));
    chk({tag, "_ovr"},  int'(overrun),    int'(m_ovr));
  endtask

  typedef struct {
    bit rst;
    bit en;
    bit busy;
    bit clr;
    bit tick;
    int num;
    bit pend;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit e, input bit b, input bit c,
                     input bit t, input int n, input bit p);
    vec_t v;
    v.rst = r; v.en = e; v.busy = b; v.clr = c;
    v.tick = t; v.num = n; v.pend = p;
    vecs.push_back(v);
  endtask

  initial begin
    int  tick_cnt;
    int  prev_num;
    bit  prev_tick;
    bit  saw_wrap;
    bit  glitch;
    bit  rb;

    reset = 1'b1; enable = 1'b0; draw_busy = 1'b0; clear_overrun = 1'b0;

    // ---------------- directed table ----------------
    add(1,0,0,0, 0,0,0);
    add(1,1,0,0, 0,0,0);
    // startup: IDLE->RUN edge, then first tick on edge 5
    add(0,1,0,0, 0,0,0);
    add(0,1,0,0, 0,0,0);
    add(0,1,0,0, 0,0,0);
    add(0,1,0,0, 0,0,0);
    add(0,1,0,0, 1,1,0);
    for (int k = 2; k <= 3; k++) begin
      add(0,1,0,0, 0,k-1,0);
      add(0,1,0,0, 0,k-1,0);
      add(0,1,0,0, 0,k-1,0);
      add(0,1,0,0, 1,k,0);
    end
    // deferral: busy across TC, drops two cycles later
    add(0,1,0,0, 0,3,0);
    add(0,1,0,0, 0,3,0);
    add(0,1,0,0, 0,3,0);
    add(0,1,1,0, 0,3,1);
    add(0,1,1,0, 0,3,1);
    add(0,1,0,0, 1,4,0);
    add(0,1,0,0, 0,4,0);
    add(0,1,0,0, 1,5,0);   // still on the original 4-cycle grid
    // pause for 3 cycles at cnt=2
    add(0,1,0,0, 0,5,0);
    add(0,1,0,0, 0,5,0);
    add(0,0,0,0, 0,5,0);
    add(0,0,0,0, 0,5,0);
    add(0,0,0,0, 0,5,0);
    add(0,1,0,0, 0,5,0);
    add(0,1,0,0, 1,6,0);   // 3 cycles later than the unpaused grid
    // reset while pending
    add(0,1,0,0, 0,6,0);
    add(0,1,0,0, 0,6,0);
    add(0,1,0,0, 0,6,0);
    add(0,1,1,0, 0,6,1);
    add(1,1,1,0, 0,0,0);
    add(0,1,0,0, 0,0,0);
    add(0,1,0,0, 0,0,0);
    add(0,1,0,0, 0,0,0);
    add(0,1,0,0, 0,0,0);
    add(0,1,0,0, 1,1,0);

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].en, vecs[i].busy, vecs[i].clr);
      chk($sformatf("vec%0d_tick", i), int'(frame_tick), int'(vecs[i].tick));
      chk($sformatf("vec%0d_num", i),  int'(frame_num),  vecs[i].num);
      chk($sformatf("vec%0d_pend", i), int'(pending),    int'(vecs[i].pend));
      chk($sformatf("vec%0d_ovr", i),  int'(overrun),    0);
    end

    // ---------------- overrun sequence ----------------
    cycle(1,0,0,0);
    check_model("ovr_rst");
    for (int i = 0; i < 5; i++) begin
      cycle(0,1,0,0);
      check_model("ovr_pre");
    end
    chk("ovr_first_tick", int'(frame_tick), 1);
    tick_cnt = 0;
    for (int i = 0; i < 8; i++) begin   // busy across two boundaries
      cycle(0,1,1,0);
      check_model("ovr_busy");
      tick_cnt += int'(frame_tick);
    end
    chk("ovr_pending_held", int'(pending), 1);
    cycle(0,1,0,0);
    check_model("ovr_release");
    tick_cnt += int'(frame_tick);
    chk("ovr_single_tick", tick_cnt, 1);
    chk("ovr_flag", int'(overrun), OVR_ON);
    chk("ovr_num", int'(frame_num), 2);
    cycle(0,1,0,1);
    check_model("ovr_clear");
    chk("ovr_cleared", int'(overrun), 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0,1,1,0);
      check_model("ovr_busy2");
    end
    cycle(0,1,1,1);                     // clear coincides with new overrun
    check_model("ovr_coinc");
    chk("ovr_set_wins", int'(overrun), OVR_ON);
    cycle(0,1,0,1);
    check_model("ovr_clear2");
    chk("ovr_clear2_flag", int'(overrun), 0);
    chk("ovr_clear2_tick", int'(frame_tick), 1);

    // ---------------- frame_num wrap ----------------
    cycle(1,1,0,0);
    check_model("wrap_rst");
    prev_num  = 0;
    prev_tick = 1'b0;
    saw_wrap  = 1'b0;
    glitch    = 1'b0;
    tick_cnt  = 0;
    for (int i = 0; i < 1 + 256 * int'(N) + 4; i++) begin
      cycle(0,1,0,0);
      check_model("wrap");
      if (frame_tick && prev_tick) glitch = 1'b1;
      if (prev_num == 255 && frame_num == 8'd0 && frame_tick) saw_wrap = 1'b1;
      tick_cnt += int'(frame_tick);
      prev_num  = int'(frame_num);
      prev_tick = frame_tick;
    end
    chk("wrap_seen", int'(saw_wrap), 1);
    chk("wrap_no_glitch", int'(glitch), 0);
    chk("wrap_tick_count", tick_cnt, 257);

    // ---------------- randomized ----------------
    cycle(1,0,0,0);
    check_model("rand_rst");
    rb = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) rb = ~rb;
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 9) != 0,
            rb,
            $urandom_range(0, 15) == 0);
      check_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_tick_gen.md
# frame_tick_gen

Generates the per-frame enable pulse that drives the frame-counting and draw/erase logic. It divides the system clock into fixed-length frame periods and emits a one-cycle `frame_tick` at each frame boundary. A busy handshake with the downstream draw logic defers a tick until that logic is ready. It sits between the clock/reset source and the frame counter and box-animation FSMs.

## Interface
- `CLKS_PER_FRAME`, default 833333: clocks per frame period (50 MHz / 60 Hz); legal range ≥ 2.
- `CW`, default 20: width of the period counter; must satisfy 2^CW ≥ CLKS_PER_FRAME.
- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `enable`  input  1  run control; low pauses the generator.
- `draw_busy`  input  1  downstream draw logic is mid-operation; a tick must not be issued while high.
- `clear_overrun`  input  1  one-cycle pulse that clears `overrun`.
- `frame_tick`  output  1  registered one-cycle pulse marking a frame boundary.
- `frame_num`  output  8  count of issued ticks, mod 256.
- `pending`  output  1  high while a tick is owed but deferred.
- `overrun`  output  1  sticky flag: a frame boundary was reached while a tick was already pending.

## Operation
- Period counter `cnt` [CW-1:0] counts 0 … CLKS_PER_FRAME-1 while `enable`=1, wraps to 0 after terminal count (TC). It freezes while `enable`=0.
- FSM states:
  - IDLE: entered from reset.
    - `enable`=1 → RUN.
  - RUN:
    - `enable`=0 → IDLE.
    - At TC with `draw_busy`=0: issue tick, stay in RUN.
    - At TC with `draw_busy`=1: → PEND.
  - PEND: `cnt` keeps counting the new frame, so the period is not stretched.
    - First enabled cycle with `draw_busy`=0: issue tick → RUN.
    - `enable`=0: freeze in PEND. The tick is still owed.
- Issue tick: `frame_tick`=1 for exactly one cycle, and `frame_num` increments with wrap 255 → 0.
- TC in PEND while `draw_busy`=1: the second boundary is merged, so only one tick is owed. `overrun` is set.
- TC in PEND on the same cycle `draw_busy` falls: exactly one tick is issued. `overrun` is set.
- `pending` = (state == PEND).
- `clear_overrun` and a new overrun event in the same cycle: set wins.
- Unsigned arithmetic throughout. TC compare is `cnt == CLKS_PER_FRAME-1`, truncated to CW bits.

## Timing
- Reset values: `cnt`=0, state IDLE, `frame_tick`=0, `frame_num`=0, `pending`=0, `overrun`=0.
- Reset asserted mid-frame or mid-PEND takes effect on the next edge and discards any owed tick.
- After reset is released with `enable`=1 held, the first tick is asserted CLKS_PER_FRAME+1 edges after the first enabled edge. IDLE→RUN costs one edge, which is the only startup latency.
- Steady state with `draw_busy`=0: ticks are exactly CLKS_PER_FRAME cycles apart. A tick is registered in the cycle after TC.
- Deferred tick: asserted in the cycle after the first sampled `draw_busy`=0 in PEND. `pending` deasserts in that same cycle.
- `frame_num` updates in the same cycle `frame_tick` is high.
- `enable` low at TC: no tick, and `cnt` holds at TC. TC is re-evaluated when `enable` returns.

## Configuration
- `FRAME_TICK_OVERRUN_EN`
  - Defined: overrun detection, the sticky `overrun` flag, and `clear_overrun` are implemented as above.
  - Undefined: `overrun` is tied 0 and `clear_overrun` is ignored. Merging of missed boundaries still occurs. All other behaviour is identical.

## Test plan
- CLKS_PER_FRAME=4, `enable`=1, `draw_busy`=0 after reset → first tick at edge 5 after release, then every 4 cycles; `frame_num` reads 1, 2, 3.
- `draw_busy` high across one TC, drops 2 cycles later → `pending`=1 for 2 cycles, tick 1 cycle after the drop, the next tick still at the original 4-cycle grid, `overrun`=0.
- `draw_busy` high across two TCs → a single tick after release, `overrun`=1 (macro defined) or 0 (undefined). `clear_overrun` pulse → `overrun`=0. `clear_overrun` coincident with a new overrun → `overrun`=1.
- `enable` dropped for 3 cycles at `cnt`=2 → no tick, `cnt` holds 2, and the tick is delayed by exactly 3 cycles.
- 256 ticks → `frame_num` wraps 255 → 0 with no glitch on `frame_tick`.
- `reset` asserted while in PEND → next cycle all outputs 0, no deferred tick issued afterwards.
